// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair.
// Every operation takes 34 edges from accept to commit: PREP, 32 RUN steps, FIX.
module mdu_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              exe_i_mdu_start,
  input  logic [1:0]        exe_i_mdu_op,
  input  logic [DATA_W-1:0] exe_i_src1,
  input  logic [DATA_W-1:0] exe_i_src2,
  input  logic              exe_i_mthi,
  input  logic              exe_i_mtlo,
  input  logic [DATA_W-1:0] exe_i_mtdata,
  input  logic              exe_i_mfhilo,
  input  logic              exe_i_flush,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_div0,
  output logic              o_stallreq
);

  localparam int W = DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   src1_q, src1_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           quo_neg_q, quo_neg_d;
  logic           rem_neg_q, rem_neg_d;
  logic           dz_q, dz_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;
  logic           div0_q, div0_d;

  logic           accept;
  logic           is_signed;
  logic           is_div;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_step;
  logic [W:0]     rem_sh;
  logic           no_borrow;
  logic [W-1:0]   rem_new;
  logic [2*W-1:0] div_step;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;

  assign accept    = exe_i_mdu_start & (state_q == IDLE) & ~done_q;
  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];

  assign a_mag = (is_signed & a_q[W-1]) ? (~a_q + 1'b1) : a_q;
  assign b_mag = (is_signed & b_q[W-1]) ? (~b_q + 1'b1) : b_q;

  // Multiply: LSB-first shift-add; the multiplier lives in the low half of acc.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? a_q : {W{1'b0}})};
  assign mul_step = {mul_sum, acc_q[W-1:1]};

  // Divide: restoring, remainder in the high half, dividend/quotient in the low half.
  // The partial remainder needs W+1 bits after the shift before the compare.
  assign rem_sh    = acc_q[2*W-1:W-1];
  assign no_borrow = (rem_sh >= {1'b0, b_q});
  assign rem_new   = rem_sh[W-1:0] - b_q;
  assign div_step  = no_borrow ? {rem_new, acc_q[W-2:0], 1'b1}
                               : {acc_q[2*W-2:0], 1'b0};

  assign prod_fix = quo_neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quot_fix = quo_neg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
  assign rem_fix  = rem_neg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    src1_d    = src1_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (exe_i_mthi) hi_d = exe_i_mtdata;
        if (exe_i_mtlo) lo_d = exe_i_mtdata;
        if (accept) begin
          op_d    = exe_i_mdu_op;
          a_d     = exe_i_src1;
          b_d     = exe_i_src2;
          src1_d  = exe_i_src1;
          dz_d    = (exe_i_src2 == {W{1'b0}});
          cnt_d   = 5'd0;
          state_d = PREP;
        end
      end
      PREP: begin
        a_d       = a_mag;
        b_d       = b_mag;
        quo_neg_d = is_signed & (a_q[W-1] ^ b_q[W-1]);
        rem_neg_d = is_signed & a_q[W-1];
        acc_d     = is_div ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
        cnt_d     = 5'd0;
        state_d   = RUN;
      end
      RUN: begin
        acc_d = is_div ? div_step : mul_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (is_div) begin
          if (dz_q) begin
            hi_d   = src1_q;
            lo_d   = {W{1'b1}};
            div0_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        done_d  = 1'b1;
        cnt_d   = 5'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush cancels everything in flight, including a commit about to happen.
    if (exe_i_flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      div0_d  = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state_q   <= IDLE;
      op_q      <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      src1_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= 5'd0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      src1_q    <= src1_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign o_hi       = hi_q;
  assign o_lo       = lo_q;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;
  assign o_div0     = div0_q;
  assign o_stallreq = (exe_i_mdu_start & ~done_q) | (exe_i_mfhilo & o_busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: arithmetic results, 34-edge latency, stall,
// divide-by-zero, flush/reset aborts and MTHI/MTLO gating.
module tb_mdu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mtdata;
  logic        mfhilo;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;
  logic        stallreq;

  int vecCount  = 0;
  int missCount = 0;

  mdu_ctrl #(.DATA_W(32)) dut (
    .cpu_clk_50M     (clk),
    .cpu_rst_n       (rst_n),
    .exe_i_mdu_start (start),
    .exe_i_mdu_op    (op),
    .exe_i_src1      (src1),
    .exe_i_src2      (src2),
    .exe_i_mthi      (mthi),
    .exe_i_mtlo      (mtlo),
    .exe_i_mtdata    (mtdata),
    .exe_i_mfhilo    (mfhilo),
    .exe_i_flush     (flush),
    .o_hi            (hi),
    .o_lo            (lo),
    .o_busy          (busy),
    .o_done          (done),
    .o_div0          (div0),
    .o_stallreq      (stallreq)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation with start held until the o_done cycle plus one edge.
  task automatic applyStimulus(input string name, input logic [1:0] opc,
                               input logic [31:0] s1, input logic [31:0] s2,
                               input logic mf, input logic mt,
                               input logic [31:0] expHi, input logic [31:0] expLo,
                               input logic expDiv0);
    int   edges;
    logic stallOk;
    logic seenDone;
    op     = opc;
    src1   = s1;
    src2   = s2;
    mfhilo = mf;
    mtdata = 32'hA5A5_A5A5;
    start  = 1'b1;
    #1;
    stallOk  = (stallreq === 1'b1);
    seenDone = 1'b0;
    edges    = 0;
    step();
    while (!seenDone && edges < 60) begin
      if (done === 1'b1) begin
        seenDone = 1'b1;
      end else begin
        if (stallreq !== 1'b1) stallOk = 1'b0;
        mtlo = mt & busy;
        step();
        edges++;
      end
    end
    mtlo = 1'b0;
    #1;
    checkOutput({name, " done_seen"}, {63'd0, seenDone}, 64'd1);
    checkOutput({name, " latency"}, 64'(edges), 64'd34);
    checkOutput({name, " stall_before_done"}, {63'd0, stallOk}, 64'd1);
    checkOutput({name, " hi"}, {32'd0, hi}, {32'd0, expHi});
    checkOutput({name, " lo"}, {32'd0, lo}, {32'd0, expLo});
    checkOutput({name, " div0"}, {63'd0, div0}, {63'd0, expDiv0});
    checkOutput({name, " busy_in_done"}, {63'd0, busy}, 64'd0);
    checkOutput({name, " stall_in_done"}, {63'd0, stallreq}, 64'd0);
    step();
    checkOutput({name, " no_restart_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({name, " done_pulse"}, {63'd0, done}, 64'd0);
    start  = 1'b0;
    mfhilo = 1'b0;
  endtask

  initial begin
    int doneCount;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 2'd0;
    src1   = '0;
    src2   = '0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    mtdata = '0;
    mfhilo = 1'b0;
    flush  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    checkOutput("reset hi", {32'd0, hi}, 64'd0);
    checkOutput("reset lo", {32'd0, lo}, 64'd0);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset done", {63'd0, done}, 64'd0);
    checkOutput("reset div0", {63'd0, div0}, 64'd0);
    checkOutput("reset stall", {63'd0, stallreq}, 64'd0);

    applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
                  32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    applyStimulus("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0,
                  32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    applyStimulus("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0,
                  32'd2, 32'd14, 1'b0);
    applyStimulus("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0,
                  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    applyStimulus("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
                  32'h0000_0000, 32'h8000_0000, 1'b0);
    applyStimulus("divu_by0", 2'b11, 32'd5, 32'd0, 1'b0, 1'b0,
                  32'd5, 32'hFFFF_FFFF, 1'b1);

    mthi   = 1'b1;
    mtdata = 32'h1234_5678;
    step();
    mthi = 1'b0;
    checkOutput("mthi hi", {32'd0, hi}, 64'h1234_5678);
    checkOutput("mthi lo_kept", {32'd0, lo}, 64'hFFFF_FFFF);

    op    = 2'b00;
    src1  = 32'd3;
    src2  = 32'd5;
    start = 1'b1;
    step();
    repeat (11) step();
    checkOutput("flush busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    start = 1'b0;
    step();
    flush = 1'b0;
    checkOutput("flush busy_after", {63'd0, busy}, 64'd0);
    checkOutput("flush hi_kept", {32'd0, hi}, 64'h1234_5678);
    checkOutput("flush lo_kept", {32'd0, lo}, 64'hFFFF_FFFF);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) doneCount++;
      step();
    end
    checkOutput("flush no_done", 64'(doneCount), 64'd0);
    checkOutput("flush hi_later", {32'd0, hi}, 64'h1234_5678);

    op    = 2'b00;
    src1  = 32'd9;
    src2  = 32'd9;
    start = 1'b1;
    step();
    repeat (11) step();
    rst_n = 1'b0;
    start = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("midrst hi", {32'd0, hi}, 64'd0);
    checkOutput("midrst lo", {32'd0, lo}, 64'd0);
    checkOutput("midrst busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst done", {63'd0, done}, 64'd0);

    applyStimulus("mfhi_mtlo_busy", 2'b11, 32'd100, 32'd7, 1'b1, 1'b1,
                  32'd2, 32'd14, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
